athena_hiscore_ctrl: RTL
========================

ATHENA_HISCORE_CTRL -- requirements
Module: athena_hiscore_ctrl

Interface
REQ-001 SHALL have parameter HISCORE_START, default 32'h1000fe50, bridge byte address of hiscore byte 0 (word-aligned).
REQ-002 SHALL have parameter HISCORE_SIZE, default 32'h72, hiscore length in bytes.
REQ-003 SHALL have parameter RELEASE_IDLE, default 16, idle cycles after the last transfer before the CPU is released.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 bridge_wr  in  1  one-cycle strobe, 32-bit bridge write.
REQ-007 bridge_rd  in  1  one-cycle strobe, 32-bit bridge read.
REQ-008 bridge_addr  in  32  byte address of the access; bits [1:0] ignored.
REQ-009 bridge_wr_data  in  32  write data; byte at addr+0 in [31:24], addr+3 in [7:0].
REQ-010 bridge_rd_data  out  32  read data, same byte order; valid with bridge_rd_valid.
REQ-011 bridge_rd_valid  out  1  one-cycle pulse, read complete.
REQ-012 cpu_pause  out  1  request that the game CPU halt and release the hiscore RAM.
REQ-013 cpu_paused  in  1  CPU halted acknowledge; RAM owned by this block while both are high.
REQ-014 ram_addr  out  7  hiscore byte offset 0..HISCORE_SIZE-1.
REQ-015 ram_wdata  out  8  byte to write.
REQ-016 ram_we  out  1  write strobe, one byte per cycle.
REQ-017 ram_rdata  in  8  read data, valid the cycle after ram_addr is presented.
REQ-018 busy  out  1  high in every state except IDLE and HOLD.
REQ-019 dropped  out  1  sticky: in-window request arrived while busy; cleared only by reset.

Function
REQ-020 In-window: word address W=bridge_addr&~3 satisfies HISCORE_START <= W+k <= HISCORE_START+HISCORE_SIZE-1 for some k in 0..3; others ignored (no state change, no rd_valid, no pause).
REQ-021 States SHALL be IDLE, ACQUIRE, WRITE, READ, RESPOND, HOLD.
REQ-022 IDLE: in-window strobe latches addr/data/direction, asserts cpu_pause, goes ACQUIRE.
REQ-023 ACQUIRE: waits unbounded for cpu_paused=1, then WRITE or READ per latched direction.
REQ-024 WRITE: exactly 4 cycles, byte k (k=0..3) in cycle k; ram_we=1 only when byte k is in window; ram_addr=W+k-HISCORE_START truncated to 7 bits; then HOLD.
REQ-025 READ: presents offsets k=0..3 on 4 consecutive cycles, captures ram_rdata one cycle later; out-of-window bytes return 8'h00; then RESPOND.
REQ-026 RESPOND: one cycle, bridge_rd_valid=1 with assembled word; then HOLD; read latency from cpu_paused=1 to rd_valid = 5 cycles.
REQ-027 HOLD: cpu_pause stays 1; counter counts RELEASE_IDLE cycles; in-window strobe here restarts a transfer directly (WRITE/READ next cycle if cpu_paused=1, else ACQUIRE); expiry deasserts cpu_pause and returns IDLE.
REQ-028 In-window strobe in ACQUIRE/WRITE/READ/RESPOND SHALL be discarded and set dropped; bridge_wr and bridge_rd together: write wins.
REQ-029 cpu_paused falling while in WRITE/READ SHALL NOT abort the sequence; the block completes it (CPU side must honour pause).
REQ-030 ram_we SHALL never assert unless cpu_pause=1 and cpu_paused=1.

Reset
REQ-031 Reset SHALL force IDLE immediately, including mid-transfer; cpu_pause=0, ram_we=0, bridge_rd_valid=0, busy=0, dropped=0, bridge_rd_data=0, ram_addr=0, ram_wdata=0, counters 0.
REQ-032 A partial WRITE aborted by reset SHALL leave already-written bytes in place; no further writes after reset.

Verification
REQ-033 Write 32'hAABBCCDD to 0x1000fe50, cpu_paused raised 3 cycles after cpu_pause -> ram writes off 0..3 = AA,BB,CC,DD on consecutive cycles; cpu_pause drops 16 cycles after last write.
REQ-034 Write 32'h11223344 to 0x1000fec0 -> only off 0x70=11, 0x71=22 written; 2 non-write cycles follow; read of same addr returns 32'h11220000.
REQ-035 Read 0x1000fe54 with RAM holding 01,02,03,04 at off 4..7 -> bridge_rd_valid 5 cycles after cpu_paused, data 32'h01020304.
REQ-036 Write to 0x1000fe40 and 0x1000fec4 -> no cpu_pause, no ram_we, busy stays 0.
REQ-037 Second write during WRITE -> discarded, dropped=1; second write during HOLD -> executed without deasserting cpu_pause.
REQ-038 Assert reset in WRITE cycle 2 -> cpu_pause and ram_we 0 same cycle, only bytes 0..1 written, state IDLE.

Source files
------------

// File: rtl/athena_hiscore_ctrl.sv
// Hiscore RAM bridge: pauses the game CPU, then moves one 32-bit bridge word
// into or out of the byte-wide hiscore RAM, holding the CPU briefly for bursts.
module athena_hiscore_ctrl #(
    parameter logic [31:0] HISCORE_START = 32'h1000fe50,
    parameter logic [31:0] HISCORE_SIZE  = 32'h72,
    parameter int unsigned RELEASE_IDLE  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bridge_wr,
    input  logic        bridge_rd,
    input  logic [31:0] bridge_addr,
    input  logic [31:0] bridge_wr_data,
    output logic [31:0] bridge_rd_data,
    output logic        bridge_rd_valid,
    output logic        cpu_pause,
    input  logic        cpu_paused,
    output logic [6:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic        busy,
    output logic        dropped
);

    typedef enum logic [2:0] {
        IDLE,
        ACQUIRE,
        WRITE,
        READ,
        RESPOND,
        HOLD
    } state_t;

    localparam int unsigned     CNT_W    = (RELEASE_IDLE > 1) ? $clog2(RELEASE_IDLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_IDLE - 1);
    localparam logic [33:0]     WIN_LO   = {2'b00, HISCORE_START};
    localparam logic [33:0]     WIN_HI   = WIN_LO + {2'b00, HISCORE_SIZE} - 34'd1;

    state_t             state_q, state_d;
    logic [31:0]        word_q;
    logic [31:0]        data_q;
    logic               dir_wr_q;
    logic [1:0]         k_q;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [23:0]        rd_buf_q;
    logic [31:0]        rd_word_q;
    logic               dropped_q;

    logic [31:0]        req_word;
    logic               req_hit;
    logic [3:0]         byte_ok;
    logic               latch;
    logic               drop;
    logic [31:0]        assembled;

    // 34-bit compare keeps the window test exact near the top of the address map
    function automatic logic in_window(input logic [31:0] word, input logic [1:0] k);
        logic [33:0] a;
        a = {2'b00, word} + {32'b0, k};
        return (a >= WIN_LO) && (a <= WIN_HI);
    endfunction

    always_comb begin
        req_word = bridge_addr & ~32'd3;
        req_hit  = 1'b0;
        byte_ok  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            req_hit            = req_hit | in_window(req_word, 2'(k));
            byte_ok[2'(k)]     = in_window(word_q, 2'(k));
        end
        req_hit = req_hit & (bridge_wr | bridge_rd);
    end

    assign assembled = {rd_buf_q, byte_ok[3] ? ram_rdata : 8'h00};

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_hit) begin
                    latch   = 1'b1;
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                drop = req_hit;
                if (cpu_paused) state_d = dir_wr_q ? WRITE : READ;
            end
            WRITE: begin
                drop = req_hit;
                if (k_q == 2'd3) state_d = HOLD;
            end
            READ: begin
                drop = req_hit;
                if (k_q == 2'd3) state_d = RESPOND;
            end
            RESPOND: begin
                drop    = req_hit;
                state_d = HOLD;
            end
            HOLD: begin
                // CPU is still held, so a new request skips re-acquisition when possible
                if (req_hit) begin
                    latch = 1'b1;
                    if (cpu_paused) state_d = bridge_wr ? WRITE : READ;
                    else            state_d = ACQUIRE;
                end else if (hold_cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_pause       = (state_q != IDLE);
        busy            = (state_q != IDLE) && (state_q != HOLD);
        bridge_rd_valid = (state_q == RESPOND);
        bridge_rd_data  = (state_q == RESPOND) ? assembled : rd_word_q;
        ram_addr        = '0;
        ram_wdata       = '0;
        ram_we          = 1'b0;
        if (state_q == WRITE || state_q == READ) begin
            ram_addr = 7'(word_q + {30'b0, k_q} - HISCORE_START);
        end
        if (state_q == WRITE) begin
            case (k_q)
                2'd0:    ram_wdata = data_q[31:24];
                2'd1:    ram_wdata = data_q[23:16];
                2'd2:    ram_wdata = data_q[15:8];
                default: ram_wdata = data_q[7:0];
            endcase
            ram_we = byte_ok[k_q] & cpu_paused;
        end
        dropped = dropped_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            data_q     <= '0;
            dir_wr_q   <= 1'b0;
            k_q        <= '0;
            hold_cnt_q <= '0;
            rd_buf_q   <= '0;
            rd_word_q  <= '0;
            dropped_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                word_q   <= req_word;
                data_q   <= bridge_wr_data;
                dir_wr_q <= bridge_wr;
            end
            if (drop) dropped_q <= 1'b1;
            // 2-bit byte index wraps back to 0 on the last transfer cycle
            if (state_q == WRITE || state_q == READ) k_q <= k_q + 2'd1;
            else                                     k_q <= '0;
            if (state_q == HOLD && state_d == HOLD) hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            else                                    hold_cnt_q <= '0;
            if (state_q == READ) begin
                case (k_q)
                    2'd1:    rd_buf_q[23:16] <= byte_ok[0] ? ram_rdata : 8'h00;
                    2'd2:    rd_buf_q[15:8]  <= byte_ok[1] ? ram_rdata : 8'h00;
                    2'd3:    rd_buf_q[7:0]   <= byte_ok[2] ? ram_rdata : 8'h00;
                    default: ;
                endcase
            end
            if (state_q == RESPOND) rd_word_q <= assembled;
        end
    end

endmodule
